// File: rtl/image_scan_controller.sv
// Frame sequencer for the BMP threshold pipeline.
// After a start it holds vertical_Sync for a fixed delay. It then walks the
// image in even/odd pixel pairs, row by row, with a fixed blanking gap between
// rows. When the last pair is out it waits for the writer's write_done flag and
// closes the frame with a one-cycle frame_Done pulse.
//
// Handshake: a pair is valid in any cycle where horizontal_Pulse=1. stall acts
// as an inverted ready and is sampled at the rising edge. When it is high, the
// next cycle carries no pair and the current pair's indices and addresses hold.
// The pair that follows a stall is the next unissued pair, so none is skipped
// or repeated.
//
// Every output is a register. state_dbg exposes the FSM state for checkers:
// 0 idle, 1 vsync, 2 active, 3 hblank, 4 wait_done, 5 done.
module image_scan_controller #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int START_DELAY  = 100,
  parameter int HBLANK       = 160,
  parameter int COL_W        = 9,
  parameter int ROW_W        = 9,
  parameter int ADDR_W       = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              write_done,
  output logic              busy,
  output logic              vertical_Sync,
  output logic              horizontal_Pulse,
  output logic [ROW_W-1:0]  row_Index,
  output logic [COL_W-1:0]  col_Index,
  output logic [ADDR_W-1:0] pixel_Address_Even,
  output logic [ADDR_W-1:0] pixel_Address_Odd,
  output logic              line_End,
  output logic              frame_Done,
  output logic [2:0]        state_dbg
);

  localparam int MAX_DELAY = (START_DELAY > HBLANK) ? START_DELAY : HBLANK;
  localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH / 2 - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HBLANK - 1);
  // A row of exactly one pair has its first pair as its last pair.
  localparam logic ONE_PAIR_ROW = (LAST_COL == '0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VSYNC     = 3'd1,
    S_ACTIVE    = 3'd2,
    S_HBLANK    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] delay_cnt;

  assign state_dbg = state;

  // Frame sequencer. In ACTIVE the displayed pair has always already been
  // issued. The first pair of each row is issued on the entry edge, and later
  // pairs are issued by advancing the counters. Addresses advance by two per
  // pair, and also by two across a row wrap, which keeps memory contiguous
  // without a multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      delay_cnt          <= '0;
      busy               <= 1'b0;
      vertical_Sync      <= 1'b0;
      horizontal_Pulse   <= 1'b0;
      row_Index          <= '0;
      col_Index          <= '0;
      pixel_Address_Even <= '0;
      pixel_Address_Odd  <= '0;
      line_End           <= 1'b0;
      frame_Done         <= 1'b0;
    end else begin
      horizontal_Pulse <= 1'b0;
      line_End         <= 1'b0;
      frame_Done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state              <= S_VSYNC;
            busy               <= 1'b1;
            vertical_Sync      <= 1'b1;
            delay_cnt          <= '0;
            row_Index          <= '0;
            col_Index          <= '0;
            pixel_Address_Even <= '0;
            pixel_Address_Odd  <= '0;
          end
        end
        S_VSYNC: begin
          if (delay_cnt == VS_LAST) begin
            state              <= S_ACTIVE;
            vertical_Sync      <= 1'b0;
            horizontal_Pulse   <= 1'b1;
            line_End           <= ONE_PAIR_ROW;
            row_Index          <= '0;
            col_Index          <= '0;
            pixel_Address_Even <= '0;
            pixel_Address_Odd  <= ADDR_W'(1);
          end else begin
            delay_cnt <= delay_cnt + CNT_W'(1);
          end
        end
        S_ACTIVE: begin
          if (col_Index == LAST_COL) begin
            delay_cnt <= '0;
            if (row_Index == LAST_ROW) begin
              state <= S_WAIT_DONE;
            end else begin
              state <= S_HBLANK;
            end
          end else if (!stall) begin
            horizontal_Pulse   <= 1'b1;
            line_End           <= ((col_Index + COL_W'(1)) == LAST_COL);
            col_Index          <= col_Index + COL_W'(1);
            pixel_Address_Even <= pixel_Address_Even + ADDR_W'(2);
            pixel_Address_Odd  <= pixel_Address_Odd + ADDR_W'(2);
          end
        end
        S_HBLANK: begin
          if (delay_cnt == HB_LAST) begin
            state              <= S_ACTIVE;
            horizontal_Pulse   <= 1'b1;
            line_End           <= ONE_PAIR_ROW;
            row_Index          <= row_Index + ROW_W'(1);
            col_Index          <= '0;
            pixel_Address_Even <= pixel_Address_Even + ADDR_W'(2);
            pixel_Address_Odd  <= pixel_Address_Odd + ADDR_W'(2);
          end else begin
            delay_cnt <= delay_cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (write_done) begin
            state      <= S_DONE;
            frame_Done <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_scan_controller.sv
// Bench for image_scan_controller.
// The small instance uses an 8x4 image, a vsync delay of 3 and an hblank of 2.
// It runs directed frames that are checked against a cycle table, and
// randomized-stall frames. The expected pair stream for every frame is
// computed from row*W + 2*col and consumed in order by a monitor. A second,
// medium-size instance runs one unstalled frame and has its totals checked.
module tb_image_scan_controller;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int SD = 3;
  localparam int HB = 2;
  localparam int PAIRS = (W / 2) * H;
  localparam int LIMIT = 600;

  localparam int W2 = 64;
  localparam int H2 = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic write_done = 1'b0;
  logic busy, vertical_Sync, horizontal_Pulse, line_End, frame_Done;
  logic [2:0] row_Index, col_Index;
  logic [5:0] pixel_Address_Even, pixel_Address_Odd;
  logic [2:0] state_dbg;

  logic start2 = 1'b0;
  logic stall2 = 1'b0;
  logic write_done2 = 1'b1;
  logic busy2, vs2, hp2, le2, fd2;
  logic [3:0] row2;
  logic [4:0] col2;
  logic [9:0] ev2, od2;
  logic [2:0] st2;

  int total = 0;
  int bad = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  image_scan_controller #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD), .HBLANK(HB),
    .COL_W(3), .ROW_W(3), .ADDR_W(6)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .write_done(write_done),
    .busy(busy), .vertical_Sync(vertical_Sync), .horizontal_Pulse(horizontal_Pulse),
    .row_Index(row_Index), .col_Index(col_Index),
    .pixel_Address_Even(pixel_Address_Even), .pixel_Address_Odd(pixel_Address_Odd),
    .line_End(line_End), .frame_Done(frame_Done), .state_dbg(state_dbg)
  );

  image_scan_controller #(
    .IMAGE_WIDTH(W2), .IMAGE_HEIGHT(H2), .START_DELAY(5), .HBLANK(3),
    .COL_W(5), .ROW_W(4), .ADDR_W(10)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stall(stall2), .write_done(write_done2),
    .busy(busy2), .vertical_Sync(vs2), .horizontal_Pulse(hp2),
    .row_Index(row2), .col_Index(col2),
    .pixel_Address_Even(ev2), .pixel_Address_Odd(od2),
    .line_End(le2), .frame_Done(fd2), .state_dbg(st2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pair record: {row[8], col[8], even[16], odd[16], line_end}
  function automatic logic [48:0] pack_pair(input int r, input int c, input int ev,
                                            input int od, input logic le);
    return {8'(r), 8'(c), 16'(ev), 16'(od), le};
  endfunction

  // Scoreboard: expected pair stream plus frame statistics.
  logic [48:0] exp_q[$];
  bit mon_en = 1'b0;
  bit in_row = 1'b0;
  logic stall_s = 1'b0;
  int pulse_cnt, le_cnt, fd_cnt;

  // Monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_row) check("stall_latency", 64'(horizontal_Pulse), 64'(!stall_s));
      if (horizontal_Pulse) begin
        pulse_cnt++;
        if (line_End) le_cnt++;
        if (exp_q.size() == 0) begin
          check("pulse_overflow", 64'(pulse_cnt), 64'(PAIRS));
        end else begin
          check("pair", 64'(pack_pair(int'(row_Index), int'(col_Index), int'(pixel_Address_Even),
                                      int'(pixel_Address_Odd), line_End)),
                64'(exp_q.pop_front()));
        end
        in_row = !line_End;
      end
      if (frame_Done) fd_cnt++;
    end
    stall_s = stall;
  end

  int p2_cnt = 0, le2_cnt = 0, fd2_cnt = 0, last_odd2 = 0;
  always @(negedge clk) begin
    if (hp2) begin
      p2_cnt++;
      last_odd2 = int'(od2);
      if (le2) le2_cnt++;
    end
    if (fd2) fd2_cnt++;
  end

  // Per-cycle recording of one frame, for the table checks.
  logic [52:0] rec[0:63];
  int last_pulse_cyc, fd_cyc, end_cyc;
  bit wait_ok;

  function automatic logic [52:0] snap();
    return {busy, vertical_Sync, horizontal_Pulse, line_End, frame_Done,
            8'(row_Index), 8'(col_Index), 16'(pixel_Address_Even), 16'(pixel_Address_Odd)};
  endfunction

  // mode: 0 no stall, 1 stall for 3 cycles at col 1, 2 random stall, 3 stray starts.
  // wd_hold < 0 ties write_done high. Otherwise write_done rises wd_hold cycles
  // after the last pair.
  task automatic do_frame(input int mode, input int wd_hold);
    int cyc;
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W / 2; c++)
        exp_q.push_back(pack_pair(r, c, r * W + 2 * c, r * W + 2 * c + 1, c == W / 2 - 1));
    pulse_cnt = 0; le_cnt = 0; fd_cnt = 0; in_row = 1'b0;
    last_pulse_cyc = 0; fd_cyc = 0; end_cyc = 0; wait_ok = 1'b1;
    mon_en = 1'b1;
    write_done = (wd_hold < 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < LIMIT) begin
      if (cyc < 64) rec[cyc] = snap();
      if (horizontal_Pulse && line_End && int'(row_Index) == H - 1) last_pulse_cyc = cyc;
      if (frame_Done) fd_cyc = cyc;
      if (wd_hold > 0 && last_pulse_cyc > 0 && cyc > last_pulse_cyc && cyc <= last_pulse_cyc + 50)
        if (!busy || frame_Done || horizontal_Pulse) wait_ok = 1'b0;
      if (!busy) begin
        end_cyc = cyc;
        break;
      end
      start = (mode == 3) && (frame_Done || cyc == 12);
      case (mode)
        1: stall = (cyc >= 5 && cyc <= 7);
        2: stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      if (wd_hold >= 0) write_done = (last_pulse_cyc > 0 && cyc - last_pulse_cyc >= wd_hold);
      tick();
      cyc++;
    end
    start = 1'b0;
    stall = 1'b0;
    check("frame_ends_in_budget", 64'(cyc < LIMIT), 64'(1));
    check("pulse_total", 64'(pulse_cnt), 64'(PAIRS));
    check("line_end_total", 64'(le_cnt), 64'(H));
    check("frame_done_once", 64'(fd_cnt), 64'(1));
    check("busy_drop_after_done", 64'(end_cyc), 64'(fd_cyc + 1));
  endtask

  typedef struct {
    int          cyc;
    logic [52:0] exp;
  } vec_t;

  function automatic logic [52:0] mk(input logic b, input logic vs, input logic p, input logic le,
                                     input logic fd, input int r, input int c, input int ev, input int od);
    return {b, vs, p, le, fd, 8'(r), 8'(c), 16'(ev), 16'(od)};
  endfunction

  initial begin
    vec_t tbl[$];
    bit ok;

    // Expected cycle table of an unstalled frame with write_done tied high.
    tbl.push_back('{1,  mk(1, 1, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{3,  mk(1, 1, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{4,  mk(1, 0, 1, 0, 0, 0, 0, 0, 1)});
    tbl.push_back('{5,  mk(1, 0, 1, 0, 0, 0, 1, 2, 3)});
    tbl.push_back('{7,  mk(1, 0, 1, 1, 0, 0, 3, 6, 7)});
    tbl.push_back('{8,  mk(1, 0, 0, 0, 0, 0, 3, 6, 7)});
    tbl.push_back('{9,  mk(1, 0, 0, 0, 0, 0, 3, 6, 7)});
    tbl.push_back('{10, mk(1, 0, 1, 0, 0, 1, 0, 8, 9)});
    tbl.push_back('{16, mk(1, 0, 1, 0, 0, 2, 0, 16, 17)});
    tbl.push_back('{25, mk(1, 0, 1, 1, 0, 3, 3, 30, 31)});
    tbl.push_back('{26, mk(1, 0, 0, 0, 0, 3, 3, 30, 31)});
    tbl.push_back('{27, mk(1, 0, 0, 0, 1, 3, 3, 30, 31)});

    // Reset.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_outputs", 64'(snap()), 64'(0));
    check("reset_state_idle", 64'(state_dbg), 64'(0));

    // Unstalled frame checked against the table.
    do_frame(0, -1);
    foreach (tbl[i]) check($sformatf("table_cyc%0d", tbl[i].cyc), 64'(rec[tbl[i].cyc]), 64'(tbl[i].exp));
    check("idle_busy_low", 64'(end_cyc), 64'(28));

    // Stall for 3 cycles after col 1 is shown.
    do_frame(1, -1);
    for (int k = 6; k <= 8; k++)
      check($sformatf("stall_hold_cyc%0d", k), 64'(rec[k]), 64'(mk(1, 0, 0, 0, 0, 0, 1, 2, 3)));
    check("stall_resume", 64'(rec[9]), 64'(mk(1, 0, 1, 0, 0, 0, 2, 4, 5)));

    // write_done held low for 51 cycles after the last pair.
    do_frame(0, 51);
    check("wait_done_hold", 64'(wait_ok), 64'(1));
    check("frame_done_after_wd", 64'(fd_cyc), 64'(last_pulse_cyc + 52));

    // Stray starts during ACTIVE and DONE have no effect; then a fresh frame.
    do_frame(3, -1);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy || vertical_Sync) ok = 1'b0;
    end
    check("start_in_done_ignored", 64'(ok), 64'(1));
    do_frame(0, -1);

    // Randomized stall with random write_done latency.
    for (int n = 0; n < 4; n++) do_frame(2, int'($urandom_range(0, 5)));

    // Reset during row 2 abandons the frame.
    mon_en = 1'b0;
    write_done = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (horizontal_Pulse && int'(row_Index) == 2) break;
      tick();
    end
    check("reached_row2", 64'(row_Index), 64'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midframe_reset_outputs", 64'(snap()), 64'(0));
    check("midframe_reset_state", 64'(state_dbg), 64'(0));
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (frame_Done || busy) ok = 1'b0;
    end
    check("no_done_after_reset", 64'(ok), 64'(1));
    do_frame(0, -1);
    mon_en = 1'b0;

    // Medium-size instance, one unstalled frame.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      if (!busy2) break;
    end
    check("dut2_idle", 64'(busy2), 64'(0));
    check("dut2_pulses", 64'(p2_cnt), 64'((W2 / 2) * H2));
    check("dut2_line_ends", 64'(le2_cnt), 64'(H2));
    check("dut2_last_odd", 64'(last_odd2), 64'(W2 * H2 - 1));
    check("dut2_frame_done", 64'(fd2_cnt), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_scan_controller.md
Name: image_scan_controller

Overview:
- Frame sequencer for the BMP threshold pipeline: on a start command, walks the image in pixel pairs (even/odd) row by row.
- Drives the per-pair horizontal pulse, row/column indices and image-memory addresses consumed by the read/threshold stages and the output writer.
- Inserts frame-start and line blanking, honours downstream stall, and closes the frame once the writer reports its write-done.

Parameters:
IMAGE_WIDTH, 768, pixels per row (even, ≥2)
IMAGE_HEIGHT, 512, rows per frame (≥1)
START_DELAY, 100, cycles of vertical_Sync before first pair (≥1)
HBLANK, 160, idle cycles between rows (≥1)
COL_W, 9, width of col_Index (holds IMAGE_WIDTH/2-1)
ROW_W, 9, width of row_Index (holds IMAGE_HEIGHT-1)
ADDR_W, 20, width of pixel addresses (holds IMAGE_WIDTH*IMAGE_HEIGHT-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin frame; honoured only in IDLE
stall  input  1  downstream not ready; freezes pair stream
write_done  input  1  frame-written flag from output writer
busy  output  1  high from first cycle after accepted start until the frame_Done cycle (inclusive)
vertical_Sync  output  1  high during frame-start delay
horizontal_Pulse  output  1  pair valid this cycle
row_Index  output  ROW_W  row of current pair
col_Index  output  COL_W  pair index within row
pixel_Address_Even  output  ADDR_W  row*IMAGE_WIDTH + 2*col
pixel_Address_Odd  output  ADDR_W  pixel_Address_Even + 1
line_End  output  1  high with the last pair of each row
frame_Done  output  1  one-cycle pulse at frame completion

Behaviour:
- All outputs registered. Reset at a rising edge forces IDLE; every output 0, all counters 0. Applies mid-frame too: the frame is abandoned, no frame_Done.
- States: IDLE, VSYNC, ACTIVE, HBLANK, WAIT_DONE, DONE.
- IDLE: start=1 -> VSYNC, busy=1 from the next cycle. start is ignored in all other states.
- VSYNC: vertical_Sync=1 for exactly START_DELAY cycles, then ACTIVE with row=0, col=0, address=0.
- ACTIVE, stall sampled 0 at the edge: the following cycle has horizontal_Pulse=1 and outputs showing the current pair. Counters then advance: col+1, address+2.
- ACTIVE, stall sampled 1 at the edge: the following cycle has horizontal_Pulse=0 and indices/addresses held. Stall has one-cycle latency. Stall is ignored outside ACTIVE.
- Pair with col=IMAGE_WIDTH/2-1: line_End=1 in the same cycle as its pulse.
  - If row<IMAGE_HEIGHT-1: -> HBLANK.
  - Else: -> WAIT_DONE.
- Addresses are incremental; no multiplier. Row wrap keeps the address contiguous: next row starts at the previous last odd address + 1.
- HBLANK: pulse 0 for HBLANK cycles. Then ACTIVE with col=0, row+1.
- Indices and addresses hold their last values in HBLANK, WAIT_DONE and DONE. They clear to 0 on entry to VSYNC.
- WAIT_DONE: waits for write_done=1, with no timeout. Then DONE: frame_Done=1 for one cycle and busy still 1. Next cycle is IDLE, busy=0. write_done is ignored outside WAIT_DONE.
- start=1 in the DONE cycle is ignored. A new frame needs start in IDLE.
- Per frame: exactly (IMAGE_WIDTH/2)*IMAGE_HEIGHT pulses and IMAGE_HEIGHT line_End pulses.
- With no stall, the first pulse occurs START_DELAY+1 cycles after the start edge.

Test Plan:
Use W=8, H=4, START_DELAY=3, HBLANK=2 unless stated.
- Reset then start at edge 0, stall=0, write_done tied 1:
  - vertical_Sync high in cycles 1-3.
  - First pulse in cycle 4 with addr 0/1.
  - Pulses in cycles 4-7 with line_End in cycle 7 (addr 6/7), gap cycles 8-9, row 1 starts at addr 8/9.
  - 16 pulses total, last addr 30/31, frame_Done exactly once.
- stall=1 for 3 cycles mid-row at col=1:
  - pulse low for 3 cycles, col/addr held.
  - resumes at col=2 without skipping or duplicating a pair; total still 16.
- write_done held 0 after the last pair:
  - stays in WAIT_DONE for 50 cycles with busy=1, frame_Done=0.
  - raising write_done -> frame_Done next cycle, then busy=0.
- start pulsed during ACTIVE and during DONE: no effect, pulse count unchanged. Second start in IDLE runs a full fresh frame from addr 0.
- reset asserted during row 2: next cycle all outputs 0 and state IDLE, with no frame_Done. A following start yields a complete 16-pulse frame.
- Default params, no stall: 196608 pulses, 512 line_End pulses, final odd address 393215.
